median_window_filter: RTL and testbench

//  Sliding-window median filter for 16-bit sensor samples, directly upstream of
//  DAC_Controller. median_out drives DAC_Controller.output_data, which the DAC

---
 rtl/median_window_filter.sv | 127 ++++++++++++
 tb/tb_median_window_filter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/median_window_filter.sv
`default_nettype none
// ============================================================================
//  Module      : median_window_filter
//  Description : Sliding-window median filter; odd-even transposition sort
//                over a shifted sample window, held median output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module median_window_filter #(
    parameter int DATA_W = 16,
    parameter int WINDOW = 5
) (
    input  logic              clock10MHz,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              busy,
    output logic [DATA_W-1:0] median_out,
    output logic              median_valid,
    output logic              sample_dropped,
    output logic [3:0]        fill_level
);

    localparam logic [3:0] c_WIN       = 4'(WINDOW);
    localparam logic [3:0] c_LAST_PASS = 4'(WINDOW - 1);
    localparam int         c_MID       = WINDOW / 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SORT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_window [WINDOW];
    logic [DATA_W-1:0] r_sort   [WINDOW];
    logic [DATA_W-1:0] w_pass   [WINDOW];
    logic [3:0]        r_pass_cnt;
    logic [3:0]        r_fill;
    logic [DATA_W-1:0] r_median;
    logic              r_median_valid;
    logic              r_sample_dropped;
    logic              w_odd_pass;

    assign w_odd_pass = r_pass_cnt[0];

    // One transposition pass: pairs starting at even or odd indices, strict
    // greater-than so equal values keep their positions.
    always_comb begin
        for (int i = 0; i < WINDOW; i++) begin
            w_pass[i] = r_sort[i];
        end
        for (int i = 0; i < WINDOW - 1; i++) begin
            if (((i % 2) == 1) == w_odd_pass) begin
                if (r_sort[i] > r_sort[i+1]) begin
                    w_pass[i]   = r_sort[i+1];
                    w_pass[i+1] = r_sort[i];
                end
            end
        end
    end

    always_ff @(posedge clock10MHz or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_pass_cnt       <= 4'd0;
            r_fill           <= 4'd0;
            r_median         <= '0;
            r_median_valid   <= 1'b0;
            r_sample_dropped <= 1'b0;
            for (int i = 0; i < WINDOW; i++) begin
                r_window[i] <= '0;
                r_sort[i]   <= '0;
            end
        end else begin
            r_median_valid   <= 1'b0;
            r_sample_dropped <= sample_valid && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (sample_valid) begin
                        for (int i = WINDOW - 1; i > 0; i--) begin
                            r_window[i] <= r_window[i-1];
                        end
                        r_window[0] <= sample_in;
                        r_fill      <= (r_fill == c_WIN) ? r_fill : r_fill + 4'd1;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_fill < c_WIN) begin
                        r_state <= S_IDLE;
                    end else begin
                        for (int i = 0; i < WINDOW; i++) begin
                            r_sort[i] <= r_window[i];
                        end
                        r_pass_cnt <= 4'd0;
                        r_state    <= S_SORT;
                    end
                end
                S_SORT: begin
                    for (int i = 0; i < WINDOW; i++) begin
                        r_sort[i] <= w_pass[i];
                    end
                    if (r_pass_cnt == c_LAST_PASS) begin
                        r_state <= S_DONE;
                    end else begin
                        r_pass_cnt <= r_pass_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    r_median       <= r_sort[c_MID];
                    r_median_valid <= 1'b1;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy           = (r_state != S_IDLE);
    assign median_out     = r_median;
    assign median_valid   = r_median_valid;
    assign sample_dropped = r_sample_dropped;
    assign fill_level     = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_median_window_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_median_window_filter
//  Description : Directed self-checking bench for median_window_filter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_median_window_filter;

    logic        clock10MHz = 1'b0;
    logic        reset;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        busy;
    logic [15:0] median_out;
    logic        median_valid;
    logic        sample_dropped;
    logic [3:0]  fill_level;

    int vectors     = 0;
    int miscompares = 0;

    median_window_filter #(.DATA_W(16), .WINDOW(5)) dut (
        .clock10MHz     (clock10MHz),
        .reset          (reset),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .busy           (busy),
        .median_out     (median_out),
        .median_valid   (median_valid),
        .sample_dropped (sample_dropped),
        .fill_level     (fill_level)
    );

    always #50 clock10MHz = ~clock10MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one sample at the coming edge; returns just after that edge.
    task automatic accept_tx(input logic [15:0] v);
        sample_valid = 1'b1;
        sample_in    = v;
        @(negedge clock10MHz);
        sample_valid = 1'b0;
    endtask

    // n = number of edges since the accept edge (inclusive) until idle.
    task automatic wait_idle(output int n);
        n = 1;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clock10MHz);
            n++;
        end
    endtask

    task automatic send(input string tag, input logic [15:0] v,
                        input logic exp_mv, input logic [15:0] exp_med);
        int n;
        accept_tx(v);
        wait_idle(n);
        check({tag, ".latency"}, 32'(n), exp_mv ? 32'd8 : 32'd2);
        check({tag, ".mvalid"}, {31'd0, median_valid}, {31'd0, exp_mv});
        check({tag, ".median"}, {16'd0, median_out}, {16'd0, exp_med});
    endtask

    initial begin
        int n;
        logic [15:0] exp6 [3];
        exp6[0] = 16'd4;
        exp6[1] = 16'd5;
        exp6[2] = 16'd9;

        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 16'd0;
        repeat (2) @(negedge clock10MHz);
        check("rst.busy",    {31'd0, busy},           32'd0);
        check("rst.median",  {16'd0, median_out},     32'd0);
        check("rst.mvalid",  {31'd0, median_valid},   32'd0);
        check("rst.dropped", {31'd0, sample_dropped}, 32'd0);
        check("rst.fill",    {28'd0, fill_level},     32'd0);
        reset = 1'b0;
        @(negedge clock10MHz);

        // Fill and first median
        send("t1.s1", 16'd10, 1'b0, 16'd0);
        send("t1.s2", 16'd50, 1'b0, 16'd0);
        send("t1.s3", 16'd30, 1'b0, 16'd0);
        send("t1.s4", 16'd20, 1'b0, 16'd0);
        check("t1.fill4", {28'd0, fill_level}, 32'd4);
        send("t1.s5", 16'd40, 1'b1, 16'd30);
        check("t1.fill5", {28'd0, fill_level}, 32'd5);
        @(negedge clock10MHz);
        check("t1.mv_pulse_end", {31'd0, median_valid}, 32'd0);

        // Impulse rejection
        send("t2.a", 16'd1000, 1'b1, 16'd40);
        send("t2.b", 16'd1000, 1'b1, 16'd40);
        send("t2.c", 16'd1000, 1'b1, 16'd1000);
        send("t2.d", 16'd1000, 1'b1, 16'd1000);
        send("t2.e", 16'd1000, 1'b1, 16'd1000);
        send("t2.imp", 16'hFFFF, 1'b1, 16'd1000);
        check("t2.fill_sat", {28'd0, fill_level}, 32'd5);

        // Drop while busy
        accept_tx(16'd200);
        @(negedge clock10MHz);
        sample_valid = 1'b1;
        sample_in    = 16'd5;
        @(negedge clock10MHz);
        sample_valid = 1'b0;
        check("t3.dropped",  {31'd0, sample_dropped}, 32'd1);
        check("t3.fill",     {28'd0, fill_level},     32'd5);
        @(negedge clock10MHz);
        check("t3.drop_end", {31'd0, sample_dropped}, 32'd0);
        wait_idle(n);
        check("t3.mvalid", {31'd0, median_valid}, 32'd1);
        check("t3.median", {16'd0, median_out},   32'd1000);
        send("t3.next", 16'd300, 1'b1, 16'd1000);

        // Extremes and equal values
        send("t4.a", 16'h0000, 1'b1, 16'd300);
        send("t4.b", 16'hFFFF, 1'b1, 16'd300);
        send("t4.c", 16'hFFFF, 1'b1, 16'd300);
        send("t4.d", 16'h0000, 1'b1, 16'd300);
        send("t4.e", 16'hFFFF, 1'b1, 16'hFFFF);
        send("t4.f", 16'd7, 1'b1, 16'hFFFF);
        send("t4.g", 16'd7, 1'b1, 16'd7);
        send("t4.h", 16'd7, 1'b1, 16'd7);
        send("t4.i", 16'd7, 1'b1, 16'd7);
        send("t4.j", 16'd7, 1'b1, 16'd7);

        // Async reset during SORT
        accept_tx(16'd100);
        @(negedge clock10MHz);
        @(negedge clock10MHz);
        check("t5.pre_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("t5.busy",   {31'd0, busy},         32'd0);
        check("t5.median", {16'd0, median_out},   32'd0);
        check("t5.fill",   {28'd0, fill_level},   32'd0);
        check("t5.mvalid", {31'd0, median_valid}, 32'd0);
        @(negedge clock10MHz);
        reset = 1'b0;
        @(negedge clock10MHz);
        check("t5.mvalid_after", {31'd0, median_valid}, 32'd0);
        send("t5.s1", 16'd1, 1'b0, 16'd0);
        send("t5.s2", 16'd2, 1'b0, 16'd0);
        send("t5.s3", 16'd3, 1'b0, 16'd0);
        send("t5.s4", 16'd4, 1'b0, 16'd0);
        send("t5.s5", 16'd5, 1'b1, 16'd3);

        // Continuous offer: one accept every 8 cycles
        sample_valid = 1'b1;
        sample_in    = 16'd9;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clock10MHz);
            check($sformatf("t6.dropped[%0d]", c), {31'd0, sample_dropped},
                  (c % 8 != 1) ? 32'd1 : 32'd0);
            check($sformatf("t6.mvalid[%0d]", c), {31'd0, median_valid},
                  (c % 8 == 0) ? 32'd1 : 32'd0);
            if (c % 8 == 0) begin
                check($sformatf("t6.median[%0d]", c), {16'd0, median_out},
                      {16'd0, exp6[c/8 - 1]});
            end
        end
        sample_valid = 1'b0;
        check("t6.fill", {28'd0, fill_level}, 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
